// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan driver: double-buffered patterns, per-slot blanking, one-hot enables.
// Latency: outputs registered one cycle behind the slot state; new patterns take effect at the next frame boundary.
// Backpressure: none; load is level-sampled every cycle and the last load in a frame wins.
module display_scan_mux #(
    parameter int DIGITS        = 4,
    parameter int PRESCALE      = 1000,
    parameter int BLANK         = 16,
    parameter int EN_ACTIVE_LOW = 0
) (
    input  logic                  input_clock1_1,
    input  logic                  input_reset1_2,
    input  logic [8*DIGITS-1:0]   digits_in,
    input  logic                  load,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] EN_IDLE = {DIGITS{EN_ACTIVE_LOW != 0}};

    typedef enum logic {BLANKING, DRIVE} state_t;
    localparam state_t STATE_RST = (BLANK > 0) ? BLANKING : DRIVE;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [7:0]          shadow [DIGITS];
    logic [7:0]          active [DIGITS];
    logic                pending;
    logic                wrapped;
    logic                slot_end;
    logic                frame_end;
    logic [7:0]          seg_nxt;
    logic [DIGITS-1:0]   en_nxt;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state <= STATE_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        seg_nxt   = 8'h00;
        en_nxt    = '0;
        if (BLANK == 0) begin
            state_nxt = DRIVE;
        end else if (state == BLANKING && cnt == BLANK_LAST) begin
            state_nxt = DRIVE;
        end else if (state == DRIVE && slot_end) begin
            state_nxt = BLANKING;
        end
        if (state == DRIVE) begin
            seg_nxt = active[idx];
            en_nxt  = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            wrapped    <= 1'b0;
            frame_done <= 1'b0;
            seg_out    <= 8'h00;
            digit_en   <= EN_IDLE;
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            for (int i = 0; i < DIGITS; i++) begin
                if (load) begin
                    shadow[i] <= digits_in[8*i +: 8];
                end
            end

            // A load landing on the boundary bypasses the shadow so it is not deferred a whole frame.
            if (frame_end) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (load) begin
                        active[i] <= digits_in[8*i +: 8];
                    end else if (pending) begin
                        active[i] <= shadow[i];
                    end
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            // Delayed one cycle so the pulse lines up with the first slot-0 output update.
            wrapped    <= frame_end;
            frame_done <= wrapped;
            seg_out    <= seg_nxt;
            digit_en   <= en_nxt ^ EN_IDLE;
        end
    end

endmodule
